unified_mem_arbiter: RTL and testbench

UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

---
 rtl/unified_mem_arbiter_pkg.sv | 21 ++
 rtl/unified_mem_arbiter_timeout_counter.sv | 19 +
 rtl/unified_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_unified_mem_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// unified_mem_arbiter_pkg: shared state/size encodings, NOP constant and latched command type.
package unified_mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SERVE_DM = 2'd1, SERVE_IF = 2'd2} arb_state_e;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [31:0] NOP_INSN = 32'h00000013;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        we;
  } mem_cmd_t;
  function automatic mem_cmd_t fetch_cmd(input logic [31:0] a);
    return '{addr: a & ~32'h3, wdata: '0, size: SIZE_WORD, we: 1'b0};
  endfunction
  // The reserved size code 11 is issued to memory as a word access.
  function automatic logic [1:0] legal_size(input logic [1:0] s);
    return (s == SIZE_BYTE || s == SIZE_HALF) ? s : SIZE_WORD;
  endfunction
endpackage

// File: rtl/unified_mem_arbiter_timeout_counter.sv
// arb_timeout_counter: counts stalled service cycles; expired flags the last allowed one.
module arb_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign expired_o = en_i && (cnt_q == W'(TIMEOUT - 1));
  assign cnt_d = clear_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: fixed-priority fetch/data arbiter onto one single-port memory,
// with flush suppression of fetches and a timeout that aborts hung accesses.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  input  logic        dm_read_i,
  input  logic        dm_write_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  input  logic [1:0]  dm_size_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [1:0]  mem_size_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i,
  output logic [31:0] if_rdata_o,
  output logic [31:0] dm_rdata_o,
  output logic        if_valid_o,
  output logic        dm_valid_o,
  output logic        stall_if_o,
  output logic        stall_dm_o,
  output logic        err_o
);
  arb_state_e  state_q, state_d;
  mem_cmd_t    cmd_q, cmd_d;
  logic        flushed_q, flushed_d;
  logic        if_valid_q, if_valid_d, dm_valid_q, dm_valid_d;
  logic [31:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic        err_q, err_d;
  logic        serving, expired, done, dm_req;

  assign serving = state_q != IDLE;
  assign dm_req  = dm_read_i | dm_write_i;
  assign done    = mem_ready_i | expired;

  arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (!serving),
    .en_i      (serving && !mem_ready_i),
    .expired_o (expired)
  );

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    flushed_d  = flushed_q;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    err_d      = err_q | expired;
    unique case (state_q)
      IDLE: begin
        flushed_d = 1'b0;
        if (dm_req && !dm_valid_q) begin
          state_d = SERVE_DM;
          cmd_d   = '{addr: dm_addr_i, wdata: dm_wdata_i, size: legal_size(dm_size_i), we: dm_write_i};
        end else if (if_req_i && !if_valid_q && !if_flush_i) begin
          state_d = SERVE_IF;
          cmd_d   = fetch_cmd(if_addr_i);
        end
      end
      SERVE_DM: if (done) begin
        state_d    = IDLE;
        dm_valid_d = 1'b1;
        dm_rdata_d = cmd_q.we ? dm_rdata_q : mem_ready_i ? mem_rdata_i : '0;
      end
      SERVE_IF: begin
        flushed_d = flushed_q | if_flush_i;
        if (done) begin
          state_d    = IDLE;
          if_valid_d = !flushed_d;
          if_rdata_d = flushed_d ? if_rdata_q : mem_ready_i ? mem_rdata_i : NOP_INSN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      flushed_q  <= 1'b0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      flushed_q  <= flushed_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      err_q      <= err_d;
    end
  end

  assign mem_req_o   = serving;
  assign mem_we_o    = serving & cmd_q.we;
  assign mem_addr_o  = cmd_q.addr;
  assign mem_wdata_o = cmd_q.wdata;
  assign mem_size_o  = cmd_q.size;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_valid_o  = if_valid_q;
  assign dm_valid_o  = dm_valid_q;
  assign err_o       = err_q;
  assign stall_dm_o  = dm_req & ~dm_valid_q;
  assign stall_if_o  = (if_req_i & ~if_valid_q) | stall_dm_o;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed scenarios plus randomized traffic, checked every cycle
// against a transaction-level model of the arbiter.
module tb_unified_mem_arbiter;
  localparam int TO = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 0, if_flush = 0, dm_read = 0, dm_write = 0, mem_ready = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic [1:0] dm_size = 0;
  logic mem_req, mem_we, if_valid, dm_valid, stall_if, stall_dm, err;
  logic [31:0] mem_addr, mem_wdata, if_rdata, dm_rdata;
  logic [1:0] mem_size;
  int checks = 0, errs = 0;

  unified_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .dm_read_i(dm_read), .dm_write_i(dm_write), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_size_i(dm_size), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_size_o(mem_size), .mem_rdata_i(mem_rdata),
    .mem_ready_i(mem_ready), .if_rdata_o(if_rdata), .dm_rdata_o(dm_rdata),
    .if_valid_o(if_valid), .dm_valid_o(dm_valid), .stall_if_o(stall_if),
    .stall_dm_o(stall_dm), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the memory (0 none, 1 data, 2 fetch) and what it was granted with.
  int m_busy = 0, m_served = 0;
  logic m_fl = 0, m_we = 0, m_ifv = 0, m_dmv = 0, m_err = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_ifr = 0, m_dmr = 0;
  logic [1:0] m_size = 0;

  task automatic model_step();
    logic nifv, ndmv, fin, to;
    nifv = 0;
    ndmv = 0;
    if (rst) begin
      m_busy = 0; m_served = 0; m_fl = 0; m_we = 0; m_err = 0;
      m_ifv = 0; m_dmv = 0; m_ifr = 0; m_dmr = 0; m_addr = 0; m_wdata = 0; m_size = 0;
      return;
    end
    if (m_busy != 0) begin
      m_served++;
      to  = !mem_ready && m_served == TO;
      fin = mem_ready || to;
      if (m_busy == 2) m_fl = m_fl | if_flush;
      if (fin) begin
        if (to) m_err = 1;
        if (m_busy == 1) begin
          ndmv = 1;
          if (!m_we) m_dmr = mem_ready ? mem_rdata : 32'h0;
        end else if (!m_fl) begin
          nifv = 1;
          m_ifr = mem_ready ? mem_rdata : 32'h00000013;
        end
        m_busy = 0;
      end
    end else if ((dm_read || dm_write) && !m_dmv) begin
      m_busy = 1; m_served = 0;
      m_addr = dm_addr; m_wdata = dm_wdata; m_size = dm_size; m_we = dm_write;
    end else if (if_req && !m_ifv && !if_flush) begin
      m_busy = 2; m_served = 0; m_fl = 0;
      m_addr = {if_addr[31:2], 2'b00}; m_size = 2'b10; m_we = 0;
    end
    m_ifv = nifv;
    m_dmv = ndmv;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  always @(negedge clk) begin
    #3;
    chk("mem_req", mem_req, m_busy != 0);
    chk("mem_we", mem_we, m_busy != 0 && m_we);
    if (m_busy != 0) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_size", mem_size, m_size);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("if_valid", if_valid, m_ifv);
    chk("dm_valid", dm_valid, m_dmv);
    chk("if_rdata", if_rdata, m_ifr);
    chk("dm_rdata", dm_rdata, m_dmr);
    chk("err", err, m_err);
    chk("stall_dm", stall_dm, (dm_read | dm_write) & ~m_dmv);
    chk("stall_if", stall_if, (if_req & ~m_ifv) | ((dm_read | dm_write) & ~m_dmv));
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    bit dm_act, if_act;
    int pct, kind;
    step();
    #4;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_err", err, 0);
    chk("rst_if_valid", if_valid, 0);
    step();
    rst = 0;
    // fetch alignment and minimum latency
    step(); if_req = 1; if_addr = 32'h6;
    step(); mem_ready = 1; mem_rdata = 32'hCAFEF00D;
    #4 chk("f_req", mem_req, 1); chk("f_addr", mem_addr, 32'h4); chk("f_size", mem_size, 2'b10);
    step(); if_req = 0; mem_ready = 0;
    #4 chk("f_valid", if_valid, 1); chk("f_rdata", if_rdata, 32'hCAFEF00D);
    // data wins over fetch, fetch follows
    step(); if_req = 1; if_addr = 32'h40; dm_read = 1; dm_addr = 32'h200; dm_size = 2'b10;
    #4 chk("p_stall_n", stall_if, 1);
    step(); mem_ready = 1; mem_rdata = 32'h11111111;
    #4 chk("p_addr_dm", mem_addr, 32'h200); chk("p_stall_n1", stall_if, 1);
    step(); dm_read = 0; mem_ready = 0;
    #4 chk("p_dmv", dm_valid, 1); chk("p_dmr", dm_rdata, 32'h11111111); chk("p_stall_n2", stall_if, 1);
    step(); mem_ready = 1; mem_rdata = 32'h22222222;
    #4 chk("p_addr_if", mem_addr, 32'h40); chk("p_stall_n3", stall_if, 1);
    step(); if_req = 0; mem_ready = 0;
    #4 chk("p_ifv", if_valid, 1); chk("p_ifr", if_rdata, 32'h22222222);
    // byte store
    step(); dm_write = 1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF; dm_size = 2'b00;
    step(); mem_ready = 1; mem_rdata = 32'h55555555;
    #4 chk("s_we", mem_we, 1); chk("s_size", mem_size, 0); chk("s_wdata", mem_wdata, 32'hDEADBEEF);
    step(); dm_write = 0; mem_ready = 0;
    #4 chk("s_valid", dm_valid, 1); chk("s_rdata", dm_rdata, 32'h11111111);
    // flush during fetch service
    step(); if_req = 1; if_addr = 32'h80;
    step(); if_flush = 1;
    step();
    step(); mem_ready = 1; mem_rdata = 32'h77777777;
    step(); mem_ready = 0;
    #4 chk("fl_valid", if_valid, 0); chk("fl_req", mem_req, 0); chk("fl_rdata", if_rdata, 32'h22222222);
    step();
    #4 chk("fl_nogrant", mem_req, 0);
    step(); if_flush = 0;
    step(); mem_ready = 1; mem_rdata = 32'h88888888;
    #4 chk("fl_regrant", mem_req, 1);
    step(); if_req = 0; mem_ready = 0;
    #4 chk("fl_valid2", if_valid, 1); chk("fl_rdata2", if_rdata, 32'h88888888);
    // timeout
    step(); if_req = 1; if_addr = 32'h44;
    step(); step(); step(); step();
    #4 chk("to_req4", mem_req, 1); chk("to_err4", err, 0);
    step(); if_req = 0;
    #4 chk("to_err", err, 1); chk("to_valid", if_valid, 1); chk("to_rdata", if_rdata, 32'h13); chk("to_req", mem_req, 0);
    // reset mid data service
    step(); dm_read = 1; dm_addr = 32'h300;
    step(); #1 chk("r_req_before", mem_req, 1);
    dm_read = 0; rst = 1;
    #1 chk("r_req_async", mem_req, 0); chk("r_err", err, 0);
    step(); rst = 0;
    step(); #4 chk("r_no_valid", dm_valid, 0);
    step(); #4 chk("r_no_valid2", dm_valid, 0); chk("r_idle", mem_req, 0);
    // randomized traffic
    dm_act = 0; if_act = 0; pct = 70;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (c == 1500) begin
        dm_act = 0; if_act = 0; dm_read = 0; dm_write = 0; if_req = 0; if_flush = 0; mem_ready = 0;
        #1 rst = 1;
        #1 chk("rnd_rst_req", mem_req, 0);
        step();
        rst = 0;
      end
      if (c % 200 == 0) begin
        kind = $urandom_range(2);
        pct = kind == 0 ? 75 : kind == 1 ? 30 : 0;
      end
      if (dm_act && m_dmv && $urandom_range(3) != 0) dm_act = 0;
      else if (!dm_act && $urandom_range(99) < 30) begin
        dm_act = 1;
        kind = $urandom_range(2);
        dm_read = kind != 1; dm_write = kind != 0;
        dm_addr = $urandom; dm_wdata = $urandom; dm_size = 2'($urandom_range(2));
      end
      if (!dm_act) begin dm_read = 0; dm_write = 0; end
      if_flush = $urandom_range(99) < 8;
      if (if_flush) if_addr = $urandom;
      if (if_act && m_ifv && $urandom_range(9) < 7) if_act = 0;
      else if (!if_act && $urandom_range(99) < 40) begin
        if_act = 1;
        if_addr = $urandom;
      end
      if_req = if_act;
      mem_ready = $urandom_range(99) < pct;
      mem_rdata = $urandom;
    end
    step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
